// File: rtl/bsg_regfile_read_bypass.sv
// Read-issue / operand-capture stage in front of a 2R1W synchronous register-file RAM.
// Optional bypass event counter enabled by defining BSG_REGFILE_READ_BYPASS_CNT_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

module bsg_regfile_read_bypass
  #(parameter int width_p       = 64,
    parameter int els_p         = 32,
    parameter int zero_reg_p    = 1,
    parameter int addr_width_lp = `BSG_SAFE_CLOG2(els_p))
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   output logic                     ready_and_o,
   input  logic [addr_width_lp-1:0] rs0_addr_i,
   input  logic [addr_width_lp-1:0] rs1_addr_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   output logic                     mem_w_v_o,
   output logic [addr_width_lp-1:0] mem_w_addr_o,
   output logic [width_p-1:0]       mem_w_data_o,
   output logic                     mem_r0_v_o,
   output logic [addr_width_lp-1:0] mem_r0_addr_o,
   input  logic [width_p-1:0]       mem_r0_data_i,
   output logic                     mem_r1_v_o,
   output logic [addr_width_lp-1:0] mem_r1_addr_o,
   input  logic [width_p-1:0]       mem_r1_data_i,
   output logic                     v_o,
   output logic [width_p-1:0]       rs0_data_o,
   output logic [width_p-1:0]       rs1_data_o,
   input  logic                     yumi_i,
   output logic [15:0]              bypass_count_o);

  typedef enum logic [1:0] {EMPTY = 2'd0, FRESH = 2'd1, HELD = 2'd2} state_e;

  state_e                     state_q, state_d;
  logic [addr_width_lp-1:0]   rs0_addr_q, rs1_addr_q;
  logic                       byp0_q, byp1_q;
  logic [width_p-1:0]         byp_data_q;
  logic [width_p-1:0]         hold0_q, hold0_d, hold1_q, hold1_d;
  logic                       accept;
  logic                       new_hit0, new_hit1, cap_hit0, cap_hit1;
  logic                       zero0, zero1;
  logic [width_p-1:0]         fresh0, fresh1;

  function automatic logic is_zero_reg(input logic [addr_width_lp-1:0] a);
    return (zero_reg_p != 0) && (a == '0);
  endfunction

  // Handshake: ready_and_o/v_i form a ready-and-valid input; v_o/yumi_i is a
  // valid-then-yumi output where yumi_i may only be raised while v_o is high.
  assign ready_and_o   = (state_q == EMPTY) | yumi_i;
  assign accept        = v_i & ready_and_o;

  assign mem_w_v_o     = w_v_i & ~is_zero_reg(w_addr_i);
  assign mem_w_addr_o  = w_addr_i;
  assign mem_w_data_o  = w_data_i;
  assign mem_r0_v_o    = accept;
  assign mem_r1_v_o    = accept;
  assign mem_r0_addr_o = rs0_addr_i;
  assign mem_r1_addr_o = rs1_addr_i;

  // Same-cycle hits against the incoming request and the captured operands.
  assign new_hit0 = accept & mem_w_v_o & (w_addr_i == rs0_addr_i);
  assign new_hit1 = accept & mem_w_v_o & (w_addr_i == rs1_addr_i);
  assign cap_hit0 = mem_w_v_o & (w_addr_i == rs0_addr_q);
  assign cap_hit1 = mem_w_v_o & (w_addr_i == rs1_addr_q);

  assign zero0  = is_zero_reg(rs0_addr_q);
  assign zero1  = is_zero_reg(rs1_addr_q);
  assign fresh0 = zero0 ? '0 : (byp0_q ? byp_data_q : mem_r0_data_i);
  assign fresh1 = zero1 ? '0 : (byp1_q ? byp_data_q : mem_r1_data_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept)                state_d = FRESH;
    else if (yumi_i)           state_d = EMPTY;
    else if (state_q == FRESH) state_d = HELD;
  end

  always_comb begin
    v_o        = 1'b0;
    rs0_data_o = '0;
    rs1_data_o = '0;
    case (state_q)
      FRESH: begin
        v_o        = 1'b1;
        rs0_data_o = fresh0;
        rs1_data_o = fresh1;
      end
      HELD: begin
        v_o        = 1'b1;
        rs0_data_o = hold0_q;
        rs1_data_o = hold1_q;
      end
      default: ;
    endcase
  end

  // Hold regs snapshot the presented operands, then track later writes.
  always_comb begin
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    if (state_q == FRESH) begin
      hold0_d = cap_hit0 ? w_data_i : fresh0;
      hold1_d = cap_hit1 ? w_data_i : fresh1;
    end else if (state_q == HELD) begin
      if (cap_hit0) hold0_d = w_data_i;
      if (cap_hit1) hold1_d = w_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rs0_addr_q <= '0;
      rs1_addr_q <= '0;
      byp0_q     <= 1'b0;
      byp1_q     <= 1'b0;
      byp_data_q <= '0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      if (accept) begin
        rs0_addr_q <= rs0_addr_i;
        rs1_addr_q <= rs1_addr_i;
        byp0_q     <= new_hit0;
        byp1_q     <= new_hit1;
        byp_data_q <= w_data_i;
      end
    end
  end

`ifdef BSG_REGFILE_READ_BYPASS_CNT_EN
  logic        busy, ev0, ev1;
  logic [1:0]  inc;
  logic [16:0] sum;
  logic [15:0] cnt_q, cnt_d;

  // While busy an accept implies yumi_i, so the two event sources never overlap per port.
  assign busy = (state_q != EMPTY);
  assign ev0  = new_hit0 | (busy & ~yumi_i & cap_hit0);
  assign ev1  = new_hit1 | (busy & ~yumi_i & cap_hit1);

  always_comb begin
    inc   = {1'b0, ev0} + {1'b0, ev1};
    sum   = {1'b0, cnt_q} + {15'b0, inc};
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign bypass_count_o = cnt_q;
`else
  assign bypass_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_regfile_read_bypass.sv
// Self-checking bench for bsg_regfile_read_bypass with a read-old-data RAM model
// and an architectural register shadow used to predict operands.
module tb_bsg_regfile_read_bypass;
  localparam int W  = 64;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef BSG_REGFILE_READ_BYPASS_CNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i, ready_and_o, w_v_i, yumi_i, v_o;
  logic [AW-1:0] rs0_addr_i, rs1_addr_i, w_addr_i;
  logic [W-1:0]  w_data_i;
  logic          mem_w_v_o, mem_r0_v_o, mem_r1_v_o;
  logic [AW-1:0] mem_w_addr_o, mem_r0_addr_o, mem_r1_addr_o;
  logic [W-1:0]  mem_w_data_o, mem_r0_data_i, mem_r1_data_i;
  logic [W-1:0]  rs0_data_o, rs1_data_o;
  logic [15:0]   bypass_count_o;

  logic [W-1:0]   ram [N];
  logic [W-1:0]   arch [N];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got, expv;
  logic [15:0]    exp_cnt, exp_c;
  int             n_cmp = 0;
  int             n_err = 0;

  always #5 clk_i = ~clk_i;

  bsg_regfile_read_bypass dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .rs0_addr_i(rs0_addr_i), .rs1_addr_i(rs1_addr_i),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r0_v_o(mem_r0_v_o), .mem_r0_addr_o(mem_r0_addr_o), .mem_r0_data_i(mem_r0_data_i),
    .mem_r1_v_o(mem_r1_v_o), .mem_r1_addr_o(mem_r1_addr_o), .mem_r1_data_i(mem_r1_data_i),
    .v_o(v_o), .rs0_data_o(rs0_data_o), .rs1_data_o(rs1_data_o),
    .yumi_i(yumi_i), .bypass_count_o(bypass_count_o));

  // RAM returns pre-write contents on a same-address collision.
  always @(posedge clk_i) begin
    if (mem_w_v_o) ram[mem_w_addr_o] <= mem_w_data_o;
    if (mem_r0_v_o) mem_r0_data_i <= ram[mem_r0_addr_o];
    if (mem_r1_v_o) mem_r1_data_i <= ram[mem_r1_addr_o];
  end

  task automatic drv(input logic v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                     input logic y);
    v_i = v; rs0_addr_i = a0; rs1_addr_i = a1;
    w_v_i = wv; w_addr_i = wa; w_data_i = wd; yumi_i = y;
    if (wv && wa != 0) arch[wa] = wd;
  endtask

  task automatic push_exp(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    exp_q.push_back({arch[a0], arch[a1]});
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    drv(0, 0, 0, 0, 0, '0, 0);
    #1;
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v got=%b exp=0", v_o); end
    n_cmp++; if ({rs0_data_o, rs1_data_o} !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {rs0_data_o, rs1_data_o}); end
    n_cmp++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready_and_o); end
    n_cmp++; if (bypass_count_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", bypass_count_o); end
    exp_cnt = 16'd0;
    @(negedge clk_i); reset_n_i = 1'b1;
  endtask

  task automatic test_basic_read();
    @(negedge clk_i); drv(0, 0, 0, 1, 5, 64'hAA, 0);
    #1;
    n_cmp++; if ({mem_w_v_o, mem_w_addr_o, mem_w_data_o} !== {1'b1, 5'd5, 64'hAA}) begin
      n_err++; $display("FAIL basic_wr got=%b/%0d/%h exp=1/5/aa", mem_w_v_o, mem_w_addr_o, mem_w_data_o); end
    @(negedge clk_i); drv(0, 0, 0, 0, 0, '0, 0);
    @(negedge clk_i); drv(1, 5, 0, 0, 0, '0, 0); push_exp(5, 0);
    #1;
    n_cmp++; if ({ready_and_o, mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o} !== {1'b1, 1'b1, 5'd5, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL basic_issue got=%b %b %0d %b %0d", ready_and_o, mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o); end
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv || expv !== {64'hAA, 64'h0}) begin
      n_err++; $display("FAIL basic_data v=%b got=%h exp=%h", v_o, got, expv); end
    drv(0, 0, 0, 0, 0, '0, 1);
    #1;
    n_cmp++; if ({ready_and_o, mem_r0_v_o} !== 2'b10) begin
      n_err++; $display("FAIL basic_yumi got=%b%b exp=10", ready_and_o, mem_r0_v_o); end
    @(negedge clk_i);
    n_cmp++; if (v_o !== 1'b0 || rs0_data_o !== '0) begin
      n_err++; $display("FAIL basic_empty v=%b d=%h exp=0/0", v_o, rs0_data_o); end
    drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_same_cycle_bypass();
    @(negedge clk_i); drv(0, 0, 0, 1, 7, 64'h5555, 0);
    @(negedge clk_i); drv(1, 7, 7, 1, 7, 64'h1234, 0); push_exp(7, 7);
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
      n_err++; $display("FAIL same_cycle_data v=%b got=%h exp=%h", v_o, got, expv); end
    exp_c = cnt_en ? exp_cnt : 16'd0;
    n_cmp++; if (bypass_count_o !== exp_c) begin
      n_err++; $display("FAIL same_cycle_cnt got=%0d exp=%0d", bypass_count_o, exp_c); end
    drv(0, 0, 0, 0, 0, '0, 1);
    @(negedge clk_i); drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_hold();
    @(negedge clk_i); drv(0, 0, 0, 1, 3, 64'h33, 0);
    @(negedge clk_i); drv(1, 3, 5, 0, 0, '0, 0); push_exp(3, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
      n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
        n_err++; $display("FAIL hold_data step=%0d v=%b got=%h exp=%h", i, v_o, got, expv); end
      exp_c = cnt_en ? exp_cnt : 16'd0;
      n_cmp++; if (bypass_count_o !== exp_c) begin
        n_err++; $display("FAIL hold_cnt step=%0d got=%0d exp=%0d", i, bypass_count_o, exp_c); end
      case (i)
        0: begin drv(0, 0, 0, 1, 3, 64'h11, 0); exp_cnt = exp_cnt + 16'd1; end
        1: begin drv(0, 0, 0, 1, 3, 64'h22, 0); exp_cnt = exp_cnt + 16'd1; end
        2: drv(0, 0, 0, 1, 9, 64'h99, 0);
        default: drv(0, 0, 0, 0, 0, '0, 1);
      endcase
      push_exp(3, 5);
      #1;
      n_cmp++; if (ready_and_o !== (i == 3)) begin
        n_err++; $display("FAIL hold_ready step=%0d got=%b", i, ready_and_o); end
    end
    void'(exp_q.pop_back());
    @(negedge clk_i);
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL hold_release got=%b exp=0", v_o); end
    drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a0, a1, wa;
    logic          wv;
    logic [W-1:0]  wd;
    @(negedge clk_i); drv(1, 1, 2, 0, 0, '0, 0); push_exp(1, 2);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
      n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
        n_err++; $display("FAIL b2b_data i=%0d v=%b got=%h exp=%h", i, v_o, got, expv); end
      a0 = AW'($urandom_range(0, 7)); a1 = AW'($urandom_range(0, 7));
      wv = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      if (wv && wa != 0) exp_cnt = exp_cnt + 16'(wa == a0) + 16'(wa == a1);
      drv(1, a0, a1, wv, wa, wd, 1); push_exp(a0, a1);
      #1;
      n_cmp++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready i=%0d got=%b", i, ready_and_o); end
    end
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
      n_err++; $display("FAIL b2b_last v=%b got=%h exp=%h", v_o, got, expv); end
    exp_c = cnt_en ? exp_cnt : 16'd0;
    n_cmp++; if (bypass_count_o !== exp_c) begin
      n_err++; $display("FAIL b2b_cnt got=%0d exp=%0d", bypass_count_o, exp_c); end
    drv(0, 0, 0, 0, 0, '0, 1);
    @(negedge clk_i);
    n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", v_o); end
    drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_zero_reg();
    @(negedge clk_i); drv(0, 0, 0, 1, 0, 64'hFF, 0);
    #1;
    n_cmp++; if (mem_w_v_o !== 1'b0) begin n_err++; $display("FAIL zero_wr got=%b exp=0", mem_w_v_o); end
    @(negedge clk_i); drv(1, 0, 0, 1, 0, 64'h77, 0); push_exp(0, 0);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv || expv !== '0) begin
      n_err++; $display("FAIL zero_fresh v=%b got=%h exp=%h", v_o, got, expv); end
    exp_c = cnt_en ? exp_cnt : 16'd0;
    n_cmp++; if (bypass_count_o !== exp_c) begin
      n_err++; $display("FAIL zero_cnt got=%0d exp=%0d", bypass_count_o, exp_c); end
    drv(1, 0, 5, 0, 0, '0, 1); push_exp(0, 5);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (got !== expv) begin n_err++; $display("FAIL zero_b2b got=%h exp=%h", got, expv); end
    drv(0, 0, 0, 1, 0, 64'h55, 0); push_exp(0, 5);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
      n_err++; $display("FAIL zero_held v=%b got=%h exp=%h", v_o, got, expv); end
    drv(0, 0, 0, 0, 0, '0, 1);
    @(negedge clk_i); drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i); drv(1, 7, 7, 0, 0, '0, 0); push_exp(7, 7);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (got !== expv) begin n_err++; $display("FAIL mid_fresh got=%h exp=%h", got, expv); end
    drv(0, 0, 0, 0, 0, '0, 0); push_exp(7, 7);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv) begin n_err++; $display("FAIL mid_held v=%b got=%h exp=%h", v_o, got, expv); end
    drv(0, 0, 0, 1, 7, 64'h99, 0); push_exp(7, 7);
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (got !== expv || expv !== {64'h99, 64'h99}) begin
      n_err++; $display("FAIL mid_both got=%h exp=%h", got, expv); end
    exp_c = cnt_en ? exp_cnt : 16'd0;
    n_cmp++; if (bypass_count_o !== exp_c) begin
      n_err++; $display("FAIL mid_cnt got=%0d exp=%0d", bypass_count_o, exp_c); end
    drv(0, 0, 0, 0, 0, '0, 0);
    reset_n_i = 1'b0; exp_cnt = 16'd0;
    #1;
    n_cmp++; if ({v_o, rs0_data_o, rs1_data_o, bypass_count_o} !== '0) begin
      n_err++; $display("FAIL mid_reset v=%b d=%h/%h c=%0d exp=0", v_o, rs0_data_o, rs1_data_o, bypass_count_o); end
    @(negedge clk_i); reset_n_i = 1'b1;
    #1;
    n_cmp++; if (ready_and_o !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", ready_and_o); end
    @(negedge clk_i); drv(1, 7, 5, 0, 0, '0, 0); push_exp(7, 5);
    @(negedge clk_i);
    got = {rs0_data_o, rs1_data_o}; expv = exp_q.pop_front();
    n_cmp++; if (v_o !== 1'b1 || got !== expv) begin
      n_err++; $display("FAIL mid_after v=%b got=%h exp=%h", v_o, got, expv); end
    drv(0, 0, 0, 0, 0, '0, 1);
    @(negedge clk_i); drv(0, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ram[i]  = {$urandom, $urandom};
      arch[i] = (i == 0) ? '0 : ram[i];
    end
    mem_r0_data_i = '0;
    mem_r1_data_i = '0;
    test_reset();
    test_basic_read();
    test_same_cycle_bypass();
    test_hold();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
